// File: rtl/lcd_char_controller.sv
// lcd_char_controller: power-on init, configuration and timed 4-bit byte writes for the HD44780 character LCD
module lcd_char_controller #(
    parameter int unsigned T_PWR  = 750000,
    parameter int unsigned T_W1   = 205000,
    parameter int unsigned T_W2   = 5000,
    parameter int unsigned T_W3   = 2000,
    parameter int unsigned T_SU   = 2,
    parameter int unsigned T_EH   = 12,
    parameter int unsigned T_HOLD = 1,
    parameter int unsigned T_NGAP = 50,
    parameter int unsigned T_BYTE = 2000,
    parameter int unsigned T_CLR  = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oInitDone,
    output logic [3:0] oLCD_D,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oSF_CE0
);
    localparam logic [19:0] C_PWR  = 20'(T_PWR);
    localparam logic [19:0] C_W1   = 20'(T_W1);
    localparam logic [19:0] C_W2   = 20'(T_W2);
    localparam logic [19:0] C_W3   = 20'(T_W3);
    localparam logic [19:0] C_SU   = 20'(T_SU);
    localparam logic [19:0] C_EH   = 20'(T_EH);
    localparam logic [19:0] C_HOLD = 20'(T_HOLD);
    localparam logic [19:0] C_NGAP = 20'(T_NGAP);
    localparam logic [19:0] C_BYTE = 20'(T_BYTE);
    localparam logic [19:0] C_CLR  = 20'(T_CLR);

    typedef enum logic [2:0] {PWR_WAIT, INIT, CFG, IDLE, XFER, WAIT} state_t;
    typedef enum logic [2:0] {PH_SU, PH_EH, PH_HOLD, PH_GAP, PH_WAIT} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;
    logic        brs_q, brs_d;
    logic        lo_q, lo_d;
    logic [3:0]  d_q, d_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        expired, clear_cmd, start, start_rs;
    logic [7:0]  start_byte;

    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        return i == 2'd0 ? 8'h28 : i == 2'd1 ? 8'h06 : i == 2'd2 ? 8'h0C : 8'h01;
    endfunction

    // Next-state: each phase runs for its loaded count, then hands over to the next phase
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        idx_d      = idx_q;
        byte_d     = byte_q;
        brs_d      = brs_q;
        lo_d       = lo_q;
        d_d        = d_q;
        e_d        = e_q;
        rs_d       = rs_q;
        ready_d    = ready_q;
        done_d     = done_q;
        expired    = cnt_q <= 20'd1;
        cnt_d      = expired ? cnt_q : cnt_q - 20'd1;
        clear_cmd  = !brs_q && byte_q[7:2] == 6'd0 && byte_q[1:0] != 2'd0;
        start      = 1'b0;
        start_byte = iData;
        start_rs   = iRS;
        unique case (state_q)
            PWR_WAIT: if (expired) begin
                state_d = INIT;
                phase_d = PH_SU;
                idx_d   = 2'd0;
                d_d     = 4'h3;
                rs_d    = 1'b0;
                cnt_d   = C_SU;
            end
            INIT, CFG, XFER: if (expired) begin
                unique case (phase_q)
                    PH_SU: begin
                        phase_d = PH_EH;
                        e_d     = 1'b1;
                        cnt_d   = C_EH;
                    end
                    PH_EH: begin
                        phase_d = PH_HOLD;
                        e_d     = 1'b0;
                        cnt_d   = C_HOLD;
                    end
                    PH_HOLD: if (state_q == INIT) begin
                        phase_d = PH_WAIT;
                        cnt_d   = idx_q == 2'd0 ? C_W1 : idx_q == 2'd1 ? C_W2 : C_W3;
                    end else if (!lo_q) begin
                        phase_d = PH_GAP;
                        cnt_d   = C_NGAP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = clear_cmd ? C_CLR : C_BYTE;
                    end
                    PH_GAP: begin
                        phase_d = PH_SU;
                        lo_d    = 1'b1;
                        d_d     = byte_q[3:0];
                        cnt_d   = C_SU;
                    end
                    default: if (idx_q == 2'd3) begin
                        state_d    = CFG;
                        idx_d      = 2'd0;
                        start      = 1'b1;
                        start_byte = cfg_byte(2'd0);
                        start_rs   = 1'b0;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        phase_d = PH_SU;
                        d_d     = idx_q == 2'd2 ? 4'h2 : 4'h3;
                        cnt_d   = C_SU;
                    end
                endcase
            end
            WAIT: if (expired) begin
                if (done_q || idx_q == 2'd3) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d    = CFG;
                    idx_d      = idx_q + 2'd1;
                    start      = 1'b1;
                    start_byte = cfg_byte(idx_q + 2'd1);
                    start_rs   = 1'b0;
                end
            end
            default: if (iValid) begin
                state_d = XFER;
                ready_d = 1'b0;
                start   = 1'b1;
            end
        endcase
        if (start) begin
            byte_d  = start_byte;
            brs_d   = start_rs;
            rs_d    = start_rs;
            d_d     = start_byte[7:4];
            lo_d    = 1'b0;
            phase_d = PH_SU;
            cnt_d   = C_SU;
        end
    end

    // State and registered pin outputs; reset restarts the power-on wait
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= PWR_WAIT;
            phase_q <= PH_SU;
            cnt_q   <= C_PWR;
            idx_q   <= 2'd0;
            byte_q  <= 8'h00;
            brs_q   <= 1'b0;
            lo_q    <= 1'b0;
            d_q     <= 4'h0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            brs_q   <= brs_d;
            lo_q    <= lo_d;
            d_q     <= d_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign oLCD_D    = d_q;
    assign oLCD_E    = e_q;
    assign oLCD_RS   = rs_q;
    assign oLCD_RW   = 1'b0;
    assign oSF_CE0   = 1'b1;
    assign oReady    = ready_q;
    assign oInitDone = done_q;
endmodule

// File: tb/tb_lcd_char_controller.sv
// tb_lcd_char_controller: randomized checks of LCD init and byte strobes against a timing model
module tb_lcd_char_controller;
    localparam int T_PWR = 100, T_W1 = 40, T_W2 = 10, T_W3 = 5, T_SU = 2, T_EH = 12, T_HOLD = 1;
    localparam int T_NGAP = 50, T_BYTE = 20, T_CLR = 60;
    localparam int STROBE = T_SU + T_EH + T_HOLD;

    typedef struct packed {
        int       rise;
        int       width;
        logic [3:0] d;
        logic     rs;
    } pulse_t;

    logic       Clock = 1'b0, Reset = 1'b0, iRS = 1'b0, iValid = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW, oSF_CE0;
    logic [3:0] oLCD_D;

    int checks = 0, failures = 0, cyc = 0, done_cyc = -1, unstable = 0;
    pulse_t got_q[$], exp_q[$], cur;
    int rdy_q[$];
    logic [7:0] stim_b[$];
    logic stim_r[$];

    lcd_char_controller #(
        .T_PWR(T_PWR), .T_W1(T_W1), .T_W2(T_W2), .T_W3(T_W3), .T_SU(T_SU), .T_EH(T_EH),
        .T_HOLD(T_HOLD), .T_NGAP(T_NGAP), .T_BYTE(T_BYTE), .T_CLR(T_CLR)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iRS(iRS), .iValid(iValid),
        .oReady(oReady), .oInitDone(oInitDone), .oLCD_D(oLCD_D), .oLCD_E(oLCD_E),
        .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW), .oSF_CE0(oSF_CE0)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock or negedge Reset) cyc <= !Reset ? 0 : cyc + 1;

    // Monitor: records every E pulse (rise cycle, width, D, RS) and rising edges of oReady/oInitDone
    initial begin
        logic pe, pr, pd;
        pe = 0; pr = 0; pd = 0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                pe = 0; pr = 0; pd = 0;
            end else begin
                if (oLCD_E && !pe) cur = '{cyc, 1, oLCD_D, oLCD_RS};
                else if (oLCD_E) begin
                    cur.width++;
                    if (oLCD_D !== cur.d || oLCD_RS !== cur.rs) unstable++;
                end else if (pe) begin
                    if (oLCD_D !== cur.d || oLCD_RS !== cur.rs) unstable++;
                    got_q.push_back(cur);
                end
                if (oReady && !pr) rdy_q.push_back(cyc);
                if (oInitDone && !pd) done_cyc = cyc;
                pe = oLCD_E; pr = oReady; pd = oInitDone;
            end
        end
    end

    // Expected pulses of one byte whose high nibble appears at cycle a; returns the cycle oReady (or the next byte) starts
    function automatic int model_byte(int a, logic [7:0] b, logic rs);
        exp_q.push_back('{a + T_SU, T_EH, b[7:4], rs});
        exp_q.push_back('{a + STROBE + T_NGAP + T_SU, T_EH, b[3:0], rs});
        return a + 2 * STROBE + T_NGAP + ((!rs && b >= 8'd1 && b <= 8'd3) ? T_CLR : T_BYTE);
    endfunction

    task automatic test_reset();
        Reset = 0;
        #3;
        checks++;
        if ({oLCD_E, oLCD_D, oLCD_RS, oLCD_RW, oSF_CE0, oReady, oInitDone} !== 10'b0_0000_0_0_1_0_0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {oLCD_E, oLCD_D, oLCD_RS, oLCD_RW, oSF_CE0, oReady, oInitDone}, 10'b0_0000_0_0_1_0_0);
        end
        @(posedge Clock); #1;
        checks++;
        if ({oLCD_E, oLCD_D, oLCD_RS, oLCD_RW, oSF_CE0, oReady, oInitDone} !== 10'b0_0000_0_0_1_0_0) begin
            failures++;
            $display("FAIL reset_held got=%b exp=%b", {oLCD_E, oLCD_D, oLCD_RS, oLCD_RW, oSF_CE0, oReady, oInitDone}, 10'b0_0000_0_0_1_0_0);
        end
    endtask

    task automatic test_init(input bit poke);
        int s, cfg_start, budget;
        int w[4];
        logic [3:0] nib[4];
        logic [7:0] cfg[4];
        w = '{T_W1, T_W2, T_W3, T_W3};
        nib = '{4'h3, 4'h3, 4'h3, 4'h2};
        cfg = '{8'h28, 8'h06, 8'h0C, 8'h01};
        exp_q.delete();
        s = T_PWR;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{s + T_SU, T_EH, nib[k], 1'b0});
            s += STROBE + w[k];
        end
        cfg_start = s;
        for (int k = 0; k < 4; k++) s = model_byte(s, cfg[k], 1'b0);
        Reset = 0;
        iValid = 0;
        repeat (3) @(negedge Clock);
        got_q.delete(); rdy_q.delete(); done_cyc = -1; unstable = 0;
        Reset = 1;
        budget = 0;
        while (oInitDone !== 1'b1 && budget < s + 50) begin
            @(negedge Clock);
            budget++;
            iValid = poke && cyc < cfg_start - 1 ? 1'($urandom_range(0, 1)) : 1'b0;
            iData = 8'($urandom);
            iRS = 1'($urandom_range(0, 1));
        end
        iValid = 0;
        @(negedge Clock);
        checks++;
        if (oInitDone !== 1'b1) begin
            failures++;
            $display("FAIL init_timeout got=%b exp=1 after %0d cycles", oInitDone, budget);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL init_pulse_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                if (i >= got_q.size()) $display("FAIL init_pulse%0d got=none exp=rise%0d d=%h", i, exp_q[i].rise, exp_q[i].d);
                else $display("FAIL init_pulse%0d got=rise%0d w%0d d=%h rs=%b exp=rise%0d w%0d d=%h rs=%b", i,
                    got_q[i].rise, got_q[i].width, got_q[i].d, got_q[i].rs, exp_q[i].rise, exp_q[i].width, exp_q[i].d, exp_q[i].rs);
            end
        end
        checks++;
        if (done_cyc != s) begin
            failures++;
            $display("FAIL init_done_time got=%0d exp=%0d", done_cyc, s);
        end
        checks++;
        if (rdy_q.size() != 1 || rdy_q[0] != s) begin
            failures++;
            $display("FAIL init_ready_time got=%0d rises first=%0d exp=1 rise at %0d", rdy_q.size(), rdy_q.size() > 0 ? rdy_q[0] : -1, s);
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL init_bus_stable got=%0d changes exp=0", unstable);
        end
    endtask

    // Sends stim_b/stim_r with iValid held high throughout, changing iData only after each observed accept
    task automatic test_stream(input string name);
        int a, budget, k, n;
        bit r_prev;
        int rdy_exp[$];
        n = stim_b.size();
        exp_q.delete(); got_q.delete(); rdy_q.delete(); unstable = 0;
        budget = 0;
        while (oReady !== 1'b1 && budget < 5000) begin
            @(negedge Clock);
            budget++;
        end
        iData = stim_b[0]; iRS = stim_r[0]; iValid = 1;
        a = cyc + 1;
        for (int i = 0; i < n; i++) begin
            a = model_byte(a, stim_b[i], stim_r[i]);
            rdy_exp.push_back(a);
            a++;
        end
        r_prev = 1; k = 0; budget = 0;
        while (rdy_q.size() < n && budget < 20000) begin
            @(negedge Clock);
            budget++;
            if (r_prev && !oReady) begin
                k++;
                if (k < n) begin
                    iData = stim_b[k]; iRS = stim_r[k];
                end else iValid = 0;
            end
            r_prev = oReady;
        end
        iValid = 0;
        @(negedge Clock);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_pulse_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                if (i >= got_q.size()) $display("FAIL %s_pulse%0d got=none exp=rise%0d d=%h", name, i, exp_q[i].rise, exp_q[i].d);
                else $display("FAIL %s_pulse%0d got=rise%0d w%0d d=%h rs=%b exp=rise%0d w%0d d=%h rs=%b", name, i,
                    got_q[i].rise, got_q[i].width, got_q[i].d, got_q[i].rs, exp_q[i].rise, exp_q[i].width, exp_q[i].d, exp_q[i].rs);
            end
        end
        foreach (rdy_exp[i]) begin
            checks++;
            if (i >= rdy_q.size() || rdy_q[i] != rdy_exp[i]) begin
                failures++;
                $display("FAIL %s_ready%0d got=%0d exp=%0d", name, i, i < rdy_q.size() ? rdy_q[i] : -1, rdy_exp[i]);
            end
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL %s_bus_stable got=%0d changes exp=0", name, unstable);
        end
        stim_b.delete(); stim_r.delete();
    endtask

    task automatic test_char();
        stim_b.push_back(8'h48); stim_r.push_back(1'b1);
        test_stream("char");
    endtask

    task automatic test_clear();
        stim_b.push_back(8'h01); stim_r.push_back(1'b0);
        test_stream("clear");
    endtask

    task automatic test_back_to_back();
        stim_b.push_back(8'h41); stim_r.push_back(1'b1);
        stim_b.push_back(8'hFF); stim_r.push_back(1'b1);
        test_stream("hold_valid");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            stim_b.push_back(($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom));
            stim_r.push_back(1'($urandom_range(0, 1)));
        end
        test_stream("random");
    endtask

    task automatic test_reset_mid();
        int budget;
        budget = 0;
        while (oReady !== 1'b1 && budget < 5000) begin
            @(negedge Clock);
            budget++;
        end
        iData = 8'h5A; iRS = 1; iValid = 1;
        @(negedge Clock);
        iValid = 0;
        budget = 0;
        while (oLCD_E !== 1'b1 && budget < 200) begin
            @(negedge Clock);
            budget++;
        end
        checks++;
        if (oLCD_E !== 1'b1) begin
            failures++;
            $display("FAIL mid_e_seen got=%b exp=1", oLCD_E);
        end
        #2 Reset = 0;
        #1;
        checks++;
        if ({oLCD_E, oLCD_D, oLCD_RS, oReady, oInitDone} !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b exp=%b", {oLCD_E, oLCD_D, oLCD_RS, oReady, oInitDone}, 8'h00);
        end
        test_init(1'b0);
    endtask

    initial begin
        test_reset();
        test_init(1'b0);
        test_char();
        test_clear();
        test_back_to_back();
        test_random();
        test_init(1'b1);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lcd_char_controller.md
# lcd_char_controller

- Sequences the Spartan-3E character LCD (HD44780-compatible, 4-bit bus) on behalf of the instruction-driven datapath.
- After reset it runs the power-on initialisation and configuration by itself.
- It then accepts one byte at a time (command or character) over a valid/ready handshake and emits two timed nibble strobes per byte.
- It sits between the CPU's LCD instruction execute stage and the board LCD pins.

## Interface
Parameters (cycle counts at 50 MHz; all must be 1..2^20-1):
- T_PWR, 750000, power-on wait (15 ms)
- T_W1, 205000, wait after first init nibble (4.1 ms)
- T_W2, 5000, wait after second init nibble (100 us)
- T_W3, 2000, wait after third and fourth init nibbles (40 us)
- T_SU, 2, data/RS setup before E rises
- T_EH, 12, E high width
- T_HOLD, 1, data hold after E falls
- T_NGAP, 50, gap between high and low nibble
- T_BYTE, 2000, post-byte wait (40 us)
- T_CLR, 82000, post-byte wait for clear/home commands (1.64 ms)

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- iData  in  8  byte to write
- iRS  in  1  0 = command, 1 = character data
- iValid  in  1  byte request
- oReady  out  1  high when a byte can be accepted
- oInitDone  out  1  sticky high once init/config completes
- oLCD_D  out  4  LCD data bus (SF_D[11:8])
- oLCD_E  out  1  LCD enable strobe
- oLCD_RS  out  1  LCD register select
- oLCD_RW  out  1  constant 0 (write only)
- oSF_CE0  out  1  constant 1 (StrataFlash disabled, bus owned by LCD)

## Operation
- States: PWR_WAIT -> INIT (4 single-nibble strobes) -> CFG (4 bytes) -> IDLE <-> XFER -> WAIT.
- One 20-bit down-counter serves all waits. A nibble strobe is:
  - T_SU cycles with E=0 and D/RS driven,
  - then T_EH cycles with E=1,
  - then T_HOLD cycles with E=0, D/RS still held.
- INIT, all RS=0:
  - nibble 0x3, wait T_W1;
  - 0x3, wait T_W2;
  - 0x3, wait T_W3;
  - 0x2, wait T_W3.
- CFG: bytes 0x28, 0x06, 0x0C, 0x01 are sent as normal byte transfers, RS=0.
- Byte transfer:
  - high nibble strobe;
  - T_NGAP cycles with E=0;
  - low nibble strobe;
  - wait T_BYTE, or T_CLR when RS=0 and iData[7:2]==0 and iData!=0 (clear/home).
- After the final CFG wait: oInitDone=1, oReady=1, enter IDLE.
- Accept: a rising edge with iValid=1 and oReady=1 latches iData and iRS.
  - oReady=0 from the next cycle.
  - iData and iRS are ignored until oReady returns; there is no queue and no error flag.
- iValid during PWR_WAIT/INIT/CFG or while busy is ignored. The request is not remembered.
- Outside strobes: oLCD_E=0. oLCD_D/oLCD_RS keep their last driven values.

## Timing
- Reset values (asynchronous on Reset=0): oLCD_E=0, oLCD_D=0, oLCD_RS=0, oLCD_RW=0, oSF_CE0=1, oReady=0, oInitDone=0. State is PWR_WAIT with counter loaded with T_PWR.
- Reset release:
  - PWR_WAIT lasts T_PWR cycles;
  - first init nibble D=0x3 is driven the cycle after.
- Acceptance at edge 0:
  - cycle 1: D = high nibble, RS latched, oReady=0;
  - oLCD_E high during cycles 1+T_SU .. T_SU+T_EH.
- Low nibble:
  - driven at cycle 1+T_SU+T_EH+T_HOLD+T_NGAP;
  - E high during the following T_EH cycles after T_SU.
- oReady returns at cycle 1 + 2*(T_SU+T_EH+T_HOLD) + T_NGAP + Twait, where Twait = T_BYTE or T_CLR. With defaults and T_BYTE this is cycle 2081.
- A new acceptance is possible on the same edge oReady is first seen high (back-to-back, zero idle cycles).
- Reset asserted mid-strobe: E drops immediately (asynchronous). The full power-on sequence reruns and oInitDone clears.

## Test plan
Simulation parameters for all scenarios: T_PWR=100, T_W1=40, T_W2=10, T_W3=5, T_BYTE=20, T_CLR=60, others default.
- Reset release:
  - E stays 0 for 100 cycles;
  - then exactly 12 E pulses, each 12 cycles wide, with D = 3,3,3,2,2,8,0,6,0,C,0,1 and RS=0;
  - oInitDone and oReady rise together 60 cycles after the last pulse's hold.
- After init, iData=0x48, iRS=1 for one cycle:
  - two pulses with D=4 then D=8, RS=1;
  - oReady high again exactly 101 cycles after the accept edge.
- iData=0x01, iRS=0: D=0 then 1; oReady returns 141 cycles after accept (T_CLR path).
- Hold iValid=1 and change iData to 0xFF during a transfer of 0x41: only D=4, D=1 are strobed; 0xFF is accepted on the oReady-high edge as the next byte.
- Pulse iValid during INIT: no extra E pulses; the CFG sequence is unchanged.
- Drop Reset while E=1 in a byte transfer:
  - E, D, RS, oReady and oInitDone go 0 in the same timestep;
  - after release the 100-cycle wait and the full init sequence repeat.
